// File: rtl/memi_arb.sv
// memi_arb: fetch/debug arbiter for the single memi read port, with a one-deep
// response slot per requester and a saturating contention counter. Rev 1.0
`default_nettype none

`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 10
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

module memi_arb #(
  parameter int ADDR_W = `MEMI_SIZE_LOG,
  parameter int DATA_W = `INST_LEN,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_resp_valid,
  output logic [DATA_W-1:0] f_resp_data,
  input  logic              f_resp_ready,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  input  logic              d_resp_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {PRIO_F = 1'b0, PRIO_D = 1'b1} prio_t;

  prio_t prio;
  logic  f_elig, d_elig;
  logic  grant_f, grant_d;

  // A full slot is still eligible when it drains this cycle.
  assign f_elig = f_req_valid && (!f_resp_valid || f_resp_ready);
  assign d_elig = d_req_valid && (!d_resp_valid || d_resp_ready);

  // Grants are masked during reset so nothing is accepted while state is cleared.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (rst_n) begin
      if (f_elig && d_elig) begin
        grant_f = (prio == PRIO_F);
        grant_d = (prio == PRIO_D);
      end else begin
        grant_f = f_elig;
        grant_d = d_elig;
      end
    end
  end

  assign f_req_ready = grant_f;
  assign d_req_ready = grant_d;
  assign mem_addr    = grant_d ? d_req_addr : f_req_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_resp_valid <= 1'b0;
      f_resp_data  <= '0;
    end else if (grant_f) begin
      f_resp_valid <= 1'b1;
      f_resp_data  <= mem_data;
    end else if (f_resp_ready) begin
      f_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_resp_valid <= 1'b0;
      d_resp_data  <= '0;
    end else if (grant_d) begin
      d_resp_valid <= 1'b1;
      d_resp_data  <= mem_data;
    end else if (d_resp_ready) begin
      d_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PRIO_F;
    end else if (grant_f) begin
      prio <= PRIO_D;
    end else if (grant_d) begin
      prio <= PRIO_F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (f_elig && d_elig && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memi_arb.sv
// tb_memi_arb: directed and randomized checks of memi_arb against a
// requester-level reference model. Rev 1.0
`default_nettype none

module tb_memi_arb;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req_valid, d_req_valid, f_resp_ready, d_resp_ready;
  logic [AW-1:0] f_req_addr, d_req_addr;

  logic          f_req_ready, d_req_ready, f_resp_valid, d_resp_valid;
  logic [DW-1:0] f_resp_data, d_resp_data, mem_data;
  logic [AW-1:0] mem_addr;
  logic [7:0]    conflict_cnt;

  logic          f_req_ready2, d_req_ready2, f_resp_valid2, d_resp_valid2;
  logic [DW-1:0] f_resp_data2, d_resp_data2, mem_data2;
  logic [AW-1:0] mem_addr2;
  logic [1:0]    cnt2;

  logic [DW-1:0] mem [1024];

  assign mem_data  = mem[mem_addr];
  assign mem_data2 = mem[mem_addr2];

  always #5 clk = ~clk;

  memi_arb #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data), .f_resp_ready(f_resp_ready),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_ready(d_resp_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .conflict_cnt(conflict_cnt)
  );

  memi_arb #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready2),
    .f_resp_valid(f_resp_valid2), .f_resp_data(f_resp_data2), .f_resp_ready(f_resp_ready),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready2),
    .d_resp_valid(d_resp_valid2), .d_resp_data(d_resp_data2), .d_resp_ready(d_resp_ready),
    .mem_addr(mem_addr2), .mem_data(mem_data2), .conflict_cnt(cnt2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (index 0 = fetch, 1 = debug) ----------------
  int            m_prio;
  bit            m_v [2];
  logic [DW-1:0] m_d [2];
  int            m_cnt, m_cnt2;

  function automatic bit rq(int i);
    return (i == 0) ? f_req_valid : d_req_valid;
  endfunction
  function automatic bit rr(int i);
    return (i == 0) ? f_resp_ready : d_resp_ready;
  endfunction
  function automatic logic [AW-1:0] ad(int i);
    return (i == 0) ? f_req_addr : d_req_addr;
  endfunction
  function automatic bit elig(int i);
    return rq(i) && (!m_v[i] || rr(i));
  endfunction
  function automatic int winner();
    if (!rst_n) return -1;
    if (elig(0) && elig(1)) return m_prio;
    if (elig(0)) return 0;
    if (elig(1)) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prio <= 0;
      m_cnt  <= 0;
      m_cnt2 <= 0;
      for (int i = 0; i < 2; i++) begin
        m_v[i] <= 1'b0;
        m_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (winner() == i) begin
          m_v[i] <= 1'b1;
          m_d[i] <= mem[ad(i)];
        end else if (rr(i)) begin
          m_v[i] <= 1'b0;
        end
      end
      if (winner() >= 0) m_prio <= 1 - winner();
      if (elig(0) && elig(1)) begin
        m_cnt  <= (m_cnt  < 255) ? m_cnt  + 1 : m_cnt;
        m_cnt2 <= (m_cnt2 < 3)   ? m_cnt2 + 1 : m_cnt2;
      end
    end
  end

  always @(negedge clk) begin
    chk("f_req_ready", f_req_ready, winner() == 0);
    chk("d_req_ready", d_req_ready, winner() == 1);
    chk("mem_addr", mem_addr, (winner() == 1) ? d_req_addr : f_req_addr);
    chk("f_resp_valid", f_resp_valid, m_v[0]);
    chk("d_resp_valid", d_resp_valid, m_v[1]);
    if (m_v[0] || !rst_n) chk("f_resp_data", f_resp_data, m_d[0]);
    if (m_v[1] || !rst_n) chk("d_resp_data", d_resp_data, m_d[1]);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("conflict_cnt_w2", cnt2, m_cnt2);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_req_valid = 0; d_req_valid = 0; f_resp_ready = 0; d_resp_ready = 0;
    f_req_addr = '0; d_req_addr = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cyc();
    cyc();
    rst_n = 1;
  endtask

  bit exp_f [4] = '{1, 0, 1, 0};
  int exp_c2 [6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h1000_0000;
    mem[1] = 32'h1000_0001;
    mem[2] = 32'h0000_0013;
    mem[5] = 32'hAAAA_0005;
    mem[6] = 32'hDDDD_0006;
    mem[7] = 32'hDDDD_0007;
    mem[8] = 32'hDDDD_0008;
    mem[9] = 32'h9999_0009;
    idle();
    rst_n = 0;
    f_req_valid = 1;
    d_req_valid = 1;
    cyc();
    cyc();
    chk("reset f_req_ready", f_req_ready, 0);
    chk("reset d_req_ready", d_req_ready, 0);
    chk("reset f_resp_valid", f_resp_valid, 0);
    chk("reset cnt", conflict_cnt, 0);
    idle();
    rst_n = 1;

    // single fetch read
    f_req_valid = 1; f_req_addr = 2;
    @(negedge clk);
    chk("t035 f_req_ready", f_req_ready, 1);
    cyc();
    chk("t035 f_resp_valid", f_resp_valid, 1);
    chk("t035 f_resp_data", f_resp_data, 32'h0000_0013);
    idle();
    f_resp_ready = 1;
    cyc();
    do_reset();

    // contention from reset: alternating grants, counter saturation on the narrow instance
    f_req_valid = 1; d_req_valid = 1; f_req_addr = 0; d_req_addr = 1;
    f_resp_ready = 1; d_resp_ready = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) chk("t036 f_grant", f_req_ready, exp_f[k]);
      cyc();
      chk("t039 cnt_w2", cnt2, exp_c2[k]);
      if (k == 0) chk("t036 f_data", f_resp_data, 32'h1000_0000);
      if (k == 1) chk("t036 d_data", d_resp_data, 32'h1000_0001);
      if (k == 3) chk("t036 cnt", conflict_cnt, 4);
    end
    idle();
    do_reset();

    // stalled fetch consumer must not block debug
    f_req_valid = 1; f_req_addr = 5;
    cyc();
    d_req_valid = 1; d_resp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      d_req_addr = AW'(6 + k);
      @(negedge clk);
      chk("t037 f_req_ready", f_req_ready, 0);
      chk("t037 d_req_ready", d_req_ready, 1);
      cyc();
      chk("t037 f_resp_data", f_resp_data, 32'hAAAA_0005);
      chk("t037 d_resp_data", d_resp_data, 32'hDDDD_0006 + k);
    end

    // drain and refill fetch slot in the same cycle
    d_req_valid = 0; d_resp_ready = 0;
    f_resp_ready = 1; f_req_addr = 9;
    @(negedge clk);
    chk("t038 f_req_ready", f_req_ready, 1);
    cyc();
    chk("t038 f_resp_valid", f_resp_valid, 1);
    chk("t038 f_resp_data", f_resp_data, 32'h9999_0009);

    // mid-stream reset with both slots full
    f_resp_ready = 0; d_resp_ready = 0; f_req_valid = 0;
    chk("t040 pre d_resp_valid", d_resp_valid, 1);
    #1;
    rst_n = 0;
    #1;
    chk("t040 f_resp_valid", f_resp_valid, 0);
    chk("t040 d_resp_valid", d_resp_valid, 0);
    cyc();
    rst_n = 1;
    f_req_valid = 1; d_req_valid = 1; f_resp_ready = 1; d_resp_ready = 1;
    f_req_addr = 3; d_req_addr = 4;
    @(negedge clk);
    chk("t040 f_grant", f_req_ready, 1);
    chk("t040 d_grant", d_req_ready, 0);
    cyc();

    // randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 4000; n++) begin
      f_req_valid  = ($urandom_range(0, 9) < 7);
      d_req_valid  = ($urandom_range(0, 9) < 7);
      f_resp_ready = ($urandom_range(0, 9) < 5);
      d_resp_ready = ($urandom_range(0, 9) < 6);
      f_req_addr   = AW'($urandom);
      d_req_addr   = AW'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 0;
        cyc();
        rst_n = 1;
      end else begin
        cyc();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memi_arb.md
MEMI_ARB -- requirements
Module: memi_arb

Interface
REQ-001 Parameter ADDR_W, default `MEMI_SIZE_LOG, instruction-memory word-address width.
REQ-002 Parameter DATA_W, default `INST_LEN, instruction width.
REQ-003 Parameter CNT_W, default 8, conflict-counter width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 f_req_valid  input  1  fetch requester has a read request.
REQ-007 f_req_addr  input  ADDR_W  fetch read word address.
REQ-008 f_req_ready  output  1  fetch request accepted this cycle.
REQ-009 f_resp_valid  output  1  fetch response slot holds data.
REQ-010 f_resp_data  output  DATA_W  fetch response word.
REQ-011 f_resp_ready  input  1  fetch consumer takes the response this cycle.
REQ-012 d_req_valid, d_req_addr, d_req_ready, d_resp_valid, d_resp_data, d_resp_ready SHALL mirror REQ-006..011 for the debug requester.
REQ-013 mem_addr  output  ADDR_W  address driven to the memi read port.
REQ-014 mem_data  input  DATA_W  combinational read data returned by memi for mem_addr.
REQ-015 conflict_cnt  output  CNT_W  count of cycles in which an eligible requester was denied.

Function
REQ-016 Requester X SHALL be eligible when X_req_valid=1 and either X_resp_valid=0 or X_resp_ready=1 in the same cycle.
REQ-017 At most one requester SHALL be granted per cycle; X_req_ready SHALL be 1 exactly when X is granted, combinationally.
REQ-018 If exactly one requester is eligible, it SHALL be granted.
REQ-019 If both are eligible, the requester selected by priority bit prio (0=fetch, 1=debug) SHALL be granted.
REQ-020 On every grant, prio SHALL update to point at the non-granted requester; with no grant, prio SHALL hold.
REQ-021 mem_addr SHALL equal the granted requester's address; with no grant, mem_addr SHALL equal f_req_addr.
REQ-022 On a grant to X, at the next edge X_resp_valid SHALL become 1 and X_resp_data SHALL capture mem_data. Latency is 1 cycle from acceptance to response.
REQ-023 X_resp_valid and X_resp_data SHALL hold stable until a cycle with X_resp_ready=1.
REQ-024 At that edge X_resp_valid SHALL clear, unless a new grant to X occurs in the same cycle, in which case the new data SHALL load and valid SHALL stay 1. This gives back-to-back throughput of 1 per cycle per requester.
REQ-025 X_resp_ready with X_resp_valid=0 SHALL have no effect.
REQ-026 A non-eligible requester (full slot, no drain) SHALL not be granted, regardless of prio. The other requester SHALL be granted if eligible.
REQ-027 Fetch and debug response paths SHALL be fully independent; a stalled consumer on one SHALL not block the other.
REQ-028 conflict_cnt SHALL increment by 1 in each cycle where both requesters are eligible.
REQ-029 conflict_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-030 The block SHALL add no combinational path from mem_data to any req_ready output.

Reset
REQ-031 While rst_n=0, the following SHALL be forced asynchronously: f_resp_valid=0, d_resp_valid=0, f_resp_data=0, d_resp_data=0, prio=0, conflict_cnt=0.
REQ-032 While rst_n=0, f_req_ready and d_req_ready SHALL be 0.
REQ-033 Assertion of rst_n mid-operation SHALL drop pending responses; no response SHALL appear for requests accepted in the cycle of reset assertion.
REQ-034 The first cycle after rst_n deasserts SHALL arbitrate normally, with fetch priority on contention.

Verification
REQ-035 Reset, then f_req_valid=1, f_req_addr=2, mem_data=0x00000013 -> f_req_ready=1 that cycle; next cycle f_resp_valid=1, f_resp_data=0x00000013.
REQ-036 Both valid from reset with addrs 0 and 1, both resp_ready=1, for 4 cycles -> grants F,D,F,D; conflict_cnt=4.
REQ-037 Fetch granted, f_resp_ready=0, f_req_valid held with 3 debug requests pending -> fetch not granted again; debug granted 3 consecutive cycles; f_resp_data unchanged.
REQ-038 f_resp_valid=1, f_resp_ready=1, f_req_valid=1 in the same cycle -> f_req_ready=1; next cycle f_resp_valid stays 1 with the new word.
REQ-039 CNT_W=2, both eligible for 6 cycles -> conflict_cnt reads 1,2,3,3,3,3.
REQ-040 rst_n pulsed low mid-stream with both responses valid -> both resp_valid=0 immediately; after release, prio=0 and the first contended grant goes to fetch.
